alu_seq: RTL and testbench

//   Parametrised, registered ALU with valid/ready handshakes on input and output.
//   - Single-cycle ops: add, sub, logic and shifts.
//   - Multi-cycle op: iterative shift-add multiply.
//   - Result is held until the consumer accepts it.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag bits.
// Imported by alu_seq and alu_mul_seq.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_NEG   = 1;
   localparam int FLG_CARRY = 2;
   localparam int FLG_OVF   = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// done/product are combinational so the caller captures on the final edge.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic               r_busy;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_next;

   assign w_addend = r_mplier[0] ? r_mcand : '0;
   assign w_next   = r_acc + w_addend;
   assign done     = r_busy && (r_cnt == CW'(WIDTH - 1));
   assign product  = w_next;

   // Load operands on start, then accumulate one partial product per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_acc    <= '0;
      end else if (r_busy) begin
         r_acc    <= w_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (r_cnt == CW'(WIDTH - 1)) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; MUL runs iteratively.
// Optional flags output enabled by defining ALU_FLAGS_EN.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
   ,
   output logic [3:0]       flags
`endif
);

   import alu_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   state_t             r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic               w_accept;
   logic               w_mul_start;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res;

   assign in_ready = (r_state == ST_IDLE)
                  || ((r_state == ST_DONE) && out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_mul_start = w_accept && (ctrl == OP_MUL);
   assign out_valid   = r_out_valid;
   assign result      = r_result;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_mul_start),
      .a       (a),
      .b       (b),
      .done    (w_mul_done),
      .product (w_prod)
   );

   // Single-cycle datapath evaluated on the operands being accepted
   always_comb begin
      w_res = '0;
      unique case (ctrl)
         OP_ADD:  w_res = a + b;
         OP_SUB:  w_res = a - b;
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_SLL:  w_res = a << b[SHW-1:0];
         OP_SRL:  w_res = a >> b[SHW-1:0];
         OP_MUL:  w_res = '0;
         default: w_res = '0;
      endcase
   end

`ifdef ALU_FLAGS_EN
   logic [3:0] r_flags;
   logic [3:0] w_flg;
   logic [3:0] w_mul_flg;

   assign flags = r_flags;

   // Flags for single-cycle ops; carry is a wrap check, SUB carry is no-borrow
   always_comb begin
      w_flg            = '0;
      w_flg[FLG_ZERO]  = (w_res == '0);
      w_flg[FLG_NEG]   = w_res[WIDTH-1];
      if (ctrl == OP_ADD) begin
         w_flg[FLG_CARRY] = (w_res < a);
         w_flg[FLG_OVF]   = (a[WIDTH-1] == b[WIDTH-1])
                         && (w_res[WIDTH-1] != a[WIDTH-1]);
      end else if (ctrl == OP_SUB) begin
         w_flg[FLG_CARRY] = (a >= b);
         w_flg[FLG_OVF]   = (a[WIDTH-1] != b[WIDTH-1])
                         && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
   end

   // MUL flags: overflow when the discarded upper half is nonzero
   always_comb begin
      w_mul_flg            = '0;
      w_mul_flg[FLG_ZERO]  = (w_prod[WIDTH-1:0] == '0);
      w_mul_flg[FLG_NEG]   = w_prod[WIDTH-1];
      w_mul_flg[FLG_OVF]   = |w_prod[2*WIDTH-1:WIDTH];
   end
`else
   logic w_unused_prod_hi;
   assign w_unused_prod_hi = ^w_prod[2*WIDTH-1:WIDTH];
`endif

   // Control FSM with registered result, valid and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
`ifdef ALU_FLAGS_EN
         r_flags     <= '0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  if (ctrl == OP_MUL) begin
                     r_state     <= ST_MUL;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_res;
`ifdef ALU_FLAGS_EN
                     r_flags     <= w_flg;
`endif
                  end
               end else if ((r_state == ST_DONE) && out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (w_mul_done) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_prod[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
                  r_flags     <= w_mul_flg;
`endif
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) against a transaction-level model.
// Flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   ctrl;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   obs_flg;

`ifdef ALU_FLAGS_EN
   logic [3:0] flags;
   assign obs_flg = flags;
`else
   assign obs_flg = 4'h0;
`endif

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ctrl      (ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef ALU_FLAGS_EN
      .flags     (flags),
`endif
      .result    (result)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: a pending output slot plus a MUL countdown
   bit       m_ov;
   bit [7:0] m_res;
   bit [3:0] m_flg;
   int       m_mul_left;
   int       m_ma;
   int       m_mb;

   function automatic int ref_op(int op, int x, int y);
      case (op)
         0: return x + y;
         1: return x - y;
         2: return x & y;
         3: return x | y;
         4: return x ^ y;
         5: return x << (y % 8);
         6: return x >> (y % 8);
         default: return x * y;
      endcase
   endfunction

   // Flags {ovf, carry, neg, zero} from integer arithmetic
   function automatic bit [3:0] ref_flags(int op, int x, int y);
      int full, r, sx, sy, s;
      bit ovf, carry;
      full  = ref_op(op, x, y);
      r     = full & 'hFF;
      ovf   = 1'b0;
      carry = 1'b0;
      sx    = (x >= 128) ? x - 256 : x;
      sy    = (y >= 128) ? y - 256 : y;
      if (op == 0) begin
         carry = (full > 255);
         s     = sx + sy;
         ovf   = (s > 127) || (s < -128);
      end else if (op == 1) begin
         carry = (x >= y);
         s     = sx - sy;
         ovf   = (s > 127) || (s < -128);
      end else if (op == 7) begin
         ovf   = (full > 255);
      end
      return {ovf, carry, (r >= 128), (r == 0)};
   endfunction

   function automatic bit m_ir();
      return (m_mul_left == 0) && (!m_ov || out_ready);
   endfunction

   function automatic bit [3:0] exp_flg();
`ifdef ALU_FLAGS_EN
      return m_flg;
`else
      return 4'h0;
`endif
   endfunction

   task automatic apply(input bit r, input bit v, input bit [7:0] ia,
                        input bit [7:0] ib, input bit [2:0] op,
                        input bit ordy);
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      a         = ia;
      b         = ib;
      ctrl      = op;
      out_ready = ordy;
      #1;
   endtask

   task automatic advance();
      bit acc;
      @(posedge clk);
      acc = !rst && in_valid && m_ir();
      if (rst) begin
         m_ov       = 1'b0;
         m_res      = 8'h00;
         m_flg      = 4'h0;
         m_mul_left = 0;
      end else if (m_mul_left > 0) begin
         m_mul_left--;
         if (m_mul_left == 0) begin
            m_ov  = 1'b1;
            m_res = 8'(ref_op(7, m_ma, m_mb));
            m_flg = ref_flags(7, m_ma, m_mb);
         end
      end else begin
         if (m_ov && out_ready) m_ov = 1'b0;
         if (acc) begin
            if (ctrl == 3'd7) begin
               m_mul_left = W;
               m_ma       = int'(a);
               m_mb       = int'(b);
               m_ov       = 1'b0;
            end else begin
               m_ov  = 1'b1;
               m_res = 8'(ref_op(int'(ctrl), int'(a), int'(b)));
               m_flg = ref_flags(int'(ctrl), int'(a), int'(b));
            end
         end
      end
   endtask

   task automatic test_reset();
      apply(1, 0, 8'h00, 8'h00, 3'd0, 1);
      advance();
      apply(1, 0, 8'h00, 8'h00, 3'd0, 1);
      advance();
      apply(0, 1, 8'h33, 8'h44, 3'd0, 0);
      advance();
      for (int i = 0; i < 2; i++) begin
         apply(1, 1, 8'h12, 8'h34, 3'd3, 0);
         n_cmp++;
         if ({in_ready, out_valid, result, obs_flg}
             !== {m_ir(), m_ov, m_res, exp_flg()}) begin
            n_err++;
            $display("FAIL reset_hold got %b/%b/%h/%h want %b/%b/%h/%h",
                     in_ready, out_valid, result, obs_flg,
                     m_ir(), m_ov, m_res, exp_flg());
         end
         advance();
      end
      apply(0, 0, 8'h00, 8'h00, 3'd0, 0);
      n_cmp++;
      if ({in_ready, out_valid, result, obs_flg} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
         n_err++;
         $display("FAIL reset_release got ir=%b ov=%b res=%h flg=%h want 1/0/00/0",
                  in_ready, out_valid, result, obs_flg);
      end
      advance();
   endtask

   task automatic test_add();
      apply(0, 1, 8'hF0, 8'h20, 3'd0, 1);
      advance();
      apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
      n_cmp++;
      if ({in_ready, out_valid, result, obs_flg}
          !== {m_ir(), 1'b1, 8'h10, exp_flg()}) begin
         n_err++;
         $display("FAIL add got %b/%b/%h/%h want %b/1/10/%h",
                  in_ready, out_valid, result, obs_flg, m_ir(), exp_flg());
      end
`ifdef ALU_FLAGS_EN
      n_cmp++;
      if (flags !== 4'b0100) begin
         n_err++;
         $display("FAIL add_flags got %b want 0100", flags);
      end
`endif
      advance();
   endtask

   task automatic test_sub_xor();
      apply(0, 1, 8'h04, 8'h24, 3'd1, 1);
      advance();
      apply(0, 1, 8'hFF, 8'hFF, 3'd4, 1);
      n_cmp++;
      if ({in_ready, out_valid, result, obs_flg}
          !== {1'b1, 1'b1, 8'hE0, exp_flg()}) begin
         n_err++;
         $display("FAIL sub got %b/%b/%h/%h want 1/1/e0/%h",
                  in_ready, out_valid, result, obs_flg, exp_flg());
      end
      advance();
      apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
      n_cmp++;
      if ({in_ready, out_valid, result, obs_flg}
          !== {m_ir(), 1'b1, 8'h00, exp_flg()}) begin
         n_err++;
         $display("FAIL xor_b2b got %b/%b/%h/%h want %b/1/00/%h",
                  in_ready, out_valid, result, obs_flg, m_ir(), exp_flg());
      end
      advance();
   endtask

   task automatic run_mul(input bit [7:0] x, input bit [7:0] y,
                          input bit [7:0] want);
      apply(0, 1, x, y, 3'd7, 1);
      advance();
      for (int i = 0; i <= W; i++) begin
         apply(0, (i < W), 8'($urandom), 8'($urandom), 3'($urandom), 1);
         n_cmp++;
         if ({in_ready, out_valid, result, obs_flg}
             !== {m_ir(), m_ov, m_res, exp_flg()}) begin
            n_err++;
            $display("FAIL mul_cycle%0d got %b/%b/%h/%h want %b/%b/%h/%h",
                     i, in_ready, out_valid, result, obs_flg,
                     m_ir(), m_ov, m_res, exp_flg());
         end
         if (i == W) begin
            n_cmp++;
            if ({out_valid, result} !== {1'b1, want}) begin
               n_err++;
               $display("FAIL mul_result got ov=%b res=%h want 1/%h",
                        out_valid, result, want);
            end
         end else begin
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b00) begin
               n_err++;
               $display("FAIL mul_busy%0d got ir=%b ov=%b want 0/0",
                        i, in_ready, out_valid);
            end
         end
         advance();
      end
   endtask

   task automatic test_mul();
      run_mul(8'd13, 8'd11, 8'h8F);
      run_mul(8'h10, 8'h10, 8'h00);
   endtask

   task automatic test_backpressure();
      apply(0, 1, 8'h81, 8'd9, 3'd5, 1);
      advance();
      for (int i = 0; i < 5; i++) begin
         apply(0, 1, 8'($urandom), 8'($urandom), 3'd0, 0);
         n_cmp++;
         if ({in_ready, out_valid, result, obs_flg}
             !== {1'b0, 1'b1, 8'h02, exp_flg()}) begin
            n_err++;
            $display("FAIL bp_hold%0d got %b/%b/%h/%h want 0/1/02/%h",
                     i, in_ready, out_valid, result, obs_flg, exp_flg());
         end
         advance();
      end
      apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
      n_cmp++;
      if ({in_ready, out_valid, result} !== {1'b1, 1'b1, 8'h02}) begin
         n_err++;
         $display("FAIL bp_release got %b/%b/%h want 1/1/02",
                  in_ready, out_valid, result);
      end
      advance();
      apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
      n_cmp++;
      if ({in_ready, out_valid} !== {m_ir(), 1'b0}) begin
         n_err++;
         $display("FAIL bp_idle got ir=%b ov=%b want %b/0",
                  in_ready, out_valid, m_ir());
      end
      advance();
   endtask

   task automatic test_reset_mid_mul();
      apply(0, 1, 8'd200, 8'd77, 3'd7, 1);
      advance();
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
         advance();
      end
      apply(1, 0, 8'h00, 8'h00, 3'd0, 1);
      advance();
      for (int i = 0; i < 10; i++) begin
         apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
         n_cmp++;
         if ({in_ready, out_valid, result, obs_flg}
             !== {1'b1, 1'b0, m_res, exp_flg()}) begin
            n_err++;
            $display("FAIL mulrst_quiet%0d got %b/%b/%h/%h want 1/0/%h/%h",
                     i, in_ready, out_valid, result, obs_flg,
                     m_res, exp_flg());
         end
         advance();
      end
      apply(0, 1, 8'h01, 8'h01, 3'd0, 1);
      advance();
      apply(0, 0, 8'h00, 8'h00, 3'd0, 1);
      n_cmp++;
      if ({out_valid, result} !== {1'b1, 8'h02}) begin
         n_err++;
         $display("FAIL mulrst_add got ov=%b res=%h want 1/02",
                  out_valid, result);
      end
      advance();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 59) == 0), 1'($urandom),
               8'($urandom), 8'($urandom), 3'($urandom),
               ($urandom_range(0, 3) != 0));
         n_cmp++;
         if ({in_ready, out_valid, result, obs_flg}
             !== {m_ir(), m_ov, m_res, exp_flg()}) begin
            n_err++;
            $display("FAIL rand%0d got %b/%b/%h/%h want %b/%b/%h/%h",
                     i, in_ready, out_valid, result, obs_flg,
                     m_ir(), m_ov, m_res, exp_flg());
         end
         advance();
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      ctrl       = '0;
      out_ready  = 1'b0;
      m_ov       = 1'b0;
      m_res      = 8'h00;
      m_flg      = 4'h0;
      m_mul_left = 0;
      m_ma       = 0;
      m_mb       = 0;
      test_reset();
      test_add();
      test_sub_xor();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
